// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding and direction constants for shift_seq8
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one log-shifter row of WIDTH 4:1 selects, fixed distance DIST
//
// Ports:
//   acc    in   WIDTH  current accumulator value
//   en     in   1      shamt bit for this stage (1 = shift by DIST)
//   dir    in   1      0 = left, 1 = right
//   arith  in   1      right shifts fill with the sign bit of acc
//   nxt    out  WIDTH  accumulator value after this stage
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             en,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] nxt
);

  logic             fill;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;

  always_comb begin
    fill      = arith & acc[WIDTH-1];
    // Ones in the top DIST bit positions, the ones vacated by a right shift.
    fill_mask = ~({WIDTH{1'b1}} >> DIST);
    shl       = acc << DIST;
    shr       = (acc >> DIST) | (fill ? fill_mask : '0);
    nxt       = acc;
    for (int i = 0; i < WIDTH; i++) begin
      case ({en, dir})
        {1'b1, DIR_LEFT}:  nxt[i] = shl[i];
        {1'b1, DIR_RIGHT}: nxt[i] = shr[i];
        default:           nxt[i] = acc[i];
      endcase
    end
  end

endmodule

// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - sequential barrel shifter, one log stage per clock, valid/ready in and out
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   in_valid   in   1       command/operand present
//   in_ready   out  1       command accepted this cycle when in_valid is high
//   din        in   WIDTH   operand
//   shamt      in   STAGES  shift amount
//   dir        in   1       0 = left, 1 = right
//   arith      in   1       arithmetic right shift (sign fill)
//   out_valid  out  1       dout holds a finished result
//   out_ready  in   1       consumer takes the result this cycle
//   dout       out  WIDTH   shifted result (registered)
//   busy       out  1       high while shifting
module shift_seq8
  import shift_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  din,
  input  logic [STAGES-1:0] shamt,
  input  logic              dir,
  input  logic              arith,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  dout,
  output logic              busy
);

  localparam int            CW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STAGES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  acc;
  logic [CW-1:0]     cnt;
  logic [STAGES-1:0] shamt_r;
  logic              dir_r;
  logic              arith_r;
  logic              accept;
  logic [WIDTH-1:0]  row [STAGES];
  logic [WIDTH-1:0]  stage_out;

  // All rows see the same acc; cnt picks which one is applied this cycle.
  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .acc   (acc),
      .en    (shamt_r[k]),
      .dir   (dir_r),
      .arith (arith_r),
      .nxt   (row[k])
    );
  end

  assign stage_out = row[cnt];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Result leaving this cycle frees the block for a back-to-back command.
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = S_SHIFT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      cnt     <= '0;
      dout    <= '0;
      shamt_r <= '0;
      dir_r   <= 1'b0;
      arith_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc     <= din;
        shamt_r <= shamt;
        dir_r   <= dir;
        arith_r <= arith;
        cnt     <= '0;
      end else if (state == S_SHIFT) begin
        acc <= stage_out;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) dout <= stage_out;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq8.sv
// tb/tb_shift_seq8.sv - self-checking bench for shift_seq8 with a behavioural reference model
module tb_shift_seq8;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       dir;
  logic       arith;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;
  bit rand_rdy = 1'b0;

  shift_seq8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shamt     (shamt),
    .dir       (dir),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(logic [7:0] d, logic [2:0] s, logic dr, logic ar);
    logic signed [7:0] sd;
    logic signed [7:0] sr;
    sd = d;
    if (!dr) return d << s;
    if (!ar) return d >> s;
    sr = sd >>> s;
    return sr;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: cycles left until a result appears, plus the result on offer.
  int         m_left  = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_dout  = 8'h00;
  logic [7:0] m_pend  = 8'h00;
  int         t_left;
  logic       t_valid;
  logic [7:0] t_dout;
  logic [7:0] t_pend;
  logic       t_rdy;

  always @(posedge clk) begin
    if (rst) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_dout  <= 8'h00;
    end else begin
      t_left  = m_left;
      t_valid = m_valid;
      t_dout  = m_dout;
      t_pend  = m_pend;
      t_rdy   = (m_left == 0 && !m_valid) || (m_valid && out_ready);
      if (t_valid && out_ready) t_valid = 1'b0;
      if (t_left > 0) begin
        t_left--;
        if (t_left == 0) begin
          t_valid = 1'b1;
          t_dout  = t_pend;
        end
      end
      if (in_valid && t_rdy) begin
        t_pend = ref_shift(din, shamt, dir, arith);
        t_left = LAT;
      end
      m_left  <= t_left;
      m_valid <= t_valid;
      m_dout  <= t_dout;
      m_pend  <= t_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready", 32'(in_ready), 32'((m_left == 0 && !m_valid) || (m_valid && out_ready)));
      check("busy", 32'(busy), 32'(m_left > 0));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("dout", 32'(dout), 32'(m_dout));
    end
  end

  // Called at #1 after an edge; returns at #1 after the edge that accepted the command.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic dr, input logic ar,
                      output bit ok);
    logic r;
    ok       = 1'b0;
    din      = d;
    shamt    = s;
    dir      = dr;
    arith    = ar;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Counts edges from the accepting edge to the first negedge showing out_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_lit(string name, input logic [7:0] d, input logic [2:0] s,
                         input logic dr, input logic ar, input logic [7:0] exp);
    bit ok;
    int lat;
    out_ready = 1'b1;
    send(d, s, dr, ar, ok);
    wait_result(lat);
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    check(name, 32'(dout), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    din       = 8'h00;
    shamt     = 3'd0;
    dir       = 1'b0;
    arith     = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    run_lit("lsl3", 8'b1001_0110, 3'd3, 1'b0, 1'b0, 8'b1011_0000);
    run_lit("asr2", 8'h96, 3'd2, 1'b1, 1'b1, 8'hE5);
    run_lit("lsr2", 8'h96, 3'd2, 1'b1, 1'b0, 8'h25);
    run_lit("asr7", 8'h96, 3'd7, 1'b1, 1'b1, 8'hFF);
    run_lit("shamt0", 8'h5C, 3'd0, 1'b1, 1'b1, 8'h5C);

    // Backpressure, then a command accepted in the same cycle the result leaves.
    out_ready = 1'b0;
    send(8'h96, 3'd3, 1'b0, 1'b0, ok);
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_dout", 32'(dout), 32'hB0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    din       = 8'h01;
    shamt     = 3'd7;
    dir       = 1'b0;
    arith     = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("b2b_latency", 32'(lat), 32'(LAT));
    check("b2b_dout", 32'(dout), 32'h80);
    @(posedge clk);
    #1;

    // Reset in the second shift cycle discards the command.
    send(8'h5A, 3'd1, 1'b0, 1'b0, ok);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Every operand/amount/direction/fill combination under random backpressure.
    rand_rdy = 1'b1;
    for (int c = 0; c < 8192; c++) begin
      send(c[7:0], c[10:8], c[11], c[12], ok);
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    check("drain_idle", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
